// File: rtl/voq_rd_sched.sv
// Round-robin read scheduler for the second-stage VOQ bank: one independent scheduler per output port.
// Optional grant statistics are built only when VOQ_RD_SCHED_STATS_EN is defined.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif

module voq_rd_sched #(
    parameter int PORT_NUB_TOTAL = `PORT_NUB_TOTAL,
    parameter int WIDTH_SEL      = $clog2(PORT_NUB_TOTAL),
    parameter int CNT_WIDTH      = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  sched_en,
    input  logic [PORT_NUB_TOTAL*PORT_NUB_TOTAL-1:0] empty,
    input  logic [PORT_NUB_TOTAL-1:0]             out_ready,
    output logic [PORT_NUB_TOTAL*WIDTH_SEL-1:0]   rd_sel,
    output logic [PORT_NUB_TOTAL-1:0]             rd_en,
    output logic [PORT_NUB_TOTAL-1:0]             out_vaild,
    input  logic                                  cnt_clr,
    output logic [PORT_NUB_TOTAL*CNT_WIDTH-1:0]   grant_cnt,
    output logic [2*PORT_NUB_TOTAL-1:0]           fsm_state
);

    localparam int N = PORT_NUB_TOTAL;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        STALL = 2'd2
    } state_e;

    // Handshake: a decision in cycle t (eligible && sched_en && out_ready) drives rd_en/rd_sel in t+1,
    // out_vaild follows in t+2, and the sink that raised out_ready in t must take that word.

`ifndef VOQ_RD_SCHED_STATS_EN
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
`endif

    for (genvar i = 0; i < N; i++) begin : g_port
        state_e               state_q, state_d;
        logic [WIDTH_SEL-1:0] ptr_q, ptr_d;
        logic [WIDTH_SEL-1:0] sel_q, sel_d;
        logic [WIDTH_SEL-1:0] pick, cand;
        logic [N-1:0]         elig;
        logic                 found;
        logic                 grant;
        logic                 vld_q;

        // The queue being read right now still shows its old empty flag, so it sits out one decision.
        always_comb begin
            elig = ~empty[i*N +: N];
            if (state_q == READ) begin
                elig[sel_q] = 1'b0;
            end
        end

        always_comb begin
            found = 1'b0;
            pick  = ptr_q;
            cand  = ptr_q;
            for (int s = 1; s <= N; s++) begin
                cand = ptr_q + WIDTH_SEL'(s);
                if (!found && elig[cand]) begin
                    found = 1'b1;
                    pick  = cand;
                end
            end
        end

        always_comb begin
            state_d = IDLE;
            if (sched_en && found) begin
                state_d = out_ready[i] ? READ : STALL;
            end
        end

        always_comb begin
            grant = (state_d == READ);
            sel_d = grant ? pick : sel_q;
            ptr_d = grant ? pick : ptr_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
                ptr_q   <= WIDTH_SEL'(N - 1);
                sel_q   <= '0;
                vld_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                ptr_q   <= ptr_d;
                sel_q   <= sel_d;
                vld_q   <= (state_q == READ);
            end
        end

        assign rd_en[i]                          = (state_q == READ);
        assign rd_sel[i*WIDTH_SEL +: WIDTH_SEL]  = sel_q;
        assign out_vaild[i]                      = vld_q;
        assign fsm_state[2*i +: 2]               = state_q;

`ifdef VOQ_RD_SCHED_STATS_EN
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (cnt_clr) begin
                cnt_d = '0;
            end else if ((state_q == READ) && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
`else
        assign grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] = '0;
`endif
    end

endmodule
